// File: rtl/pc_gen_if.sv
// pc_gen_if: next-PC select inputs and PC outputs of the IF-stage program-counter generator.
// master = pipeline control side, slave = pc_gen.
interface pc_gen_if #(
   parameter int WIDTH = 32
);
   logic             stall;
   logic [3:0]       npc_sel;
   logic             cond;
   logic [WIDTH-1:0] br_target;
   logic [WIDTH-1:0] j_target;
   logic [WIDTH-1:0] jr_target;
   logic             exc_req;
   logic             eret_req;
   logic [WIDTH-1:0] epc_in;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc4;
   logic [WIDTH-1:0] pc8;
   logic             pend_valid;
   logic             fetch_exc;
   logic             bad_sel;

   modport master (
      output stall, npc_sel, cond, br_target, j_target, jr_target,
             exc_req, eret_req, epc_in,
      input  pc, pc4, pc8, pend_valid, fetch_exc, bad_sel
   );

   modport slave (
      input  stall, npc_sel, cond, br_target, j_target, jr_target,
             exc_req, eret_req, epc_in,
      output pc, pc4, pc8, pend_valid, fetch_exc, bad_sel
   );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: registered PC with next-PC select, one-entry stall redirect buffer, exception/ERET vectoring when PC_EXC_EN is defined.
// Selection in cycle N lands on pc at the closing edge; stall holds pc and parks the newest redirect until stall drops.
module pc_gen #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
   parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_4180),
   parameter logic [WIDTH-1:0] IM_BASE    = WIDTH'(32'h0000_3000),
   parameter logic [WIDTH-1:0] IM_LAST    = WIDTH'(32'h0000_6FFC)
) (
   input  logic       clk,
   input  logic       reset,
   pc_gen_if.slave    bus
);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] pend_tgt_q;
   logic [WIDTH-1:0] pend_tgt_nxt;
   logic             pend_vld_q;
   logic             pend_vld_nxt;
   logic [WIDTH-1:0] pc4;
   logic             taken;
   logic [WIDTH-1:0] target;

   assign pc4 = pc_q + WIDTH'(4);

   // Undefined selects (9..15) fall into default: never taken, so they act like PC+4.
   always_comb begin
      taken  = 1'b0;
      target = bus.br_target;
      case (bus.npc_sel)
         4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
            taken  = bus.cond;
            target = bus.br_target;
         end
         4'd7: begin
            taken  = 1'b1;
            target = bus.j_target;
         end
         4'd8: begin
            taken  = 1'b1;
            target = bus.jr_target;
         end
         default: begin
            taken  = 1'b0;
            target = bus.br_target;
         end
      endcase
   end

   always_comb begin
      pc_nxt       = pc_q;
      pend_vld_nxt = pend_vld_q;
      pend_tgt_nxt = pend_tgt_q;
      if (bus.stall) begin
         if (taken) begin
            pend_tgt_nxt = target;
            pend_vld_nxt = 1'b1;
         end
      end else if (taken) begin
         pc_nxt       = target;
         pend_vld_nxt = 1'b0;
      end else if (pend_vld_q) begin
         pc_nxt       = pend_tgt_q;
         pend_vld_nxt = 1'b0;
      end else begin
         pc_nxt       = pc4;
      end
`ifdef PC_EXC_EN
      // Later assignments override: exception beats ERET beats everything else, stall included.
      if (bus.eret_req) begin
         pc_nxt       = bus.epc_in;
         pend_vld_nxt = 1'b0;
      end
      if (bus.exc_req) begin
         pc_nxt       = EXC_VECTOR;
         pend_vld_nxt = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         pend_vld_q <= 1'b0;
         pend_tgt_q <= '0;
      end else begin
         pc_q       <= pc_nxt;
         pend_vld_q <= pend_vld_nxt;
         pend_tgt_q <= pend_tgt_nxt;
      end
   end

   assign bus.pc         = pc_q;
   assign bus.pc4        = pc4;
   assign bus.pc8        = pc_q + WIDTH'(8);
   assign bus.pend_valid = pend_vld_q;
   assign bus.bad_sel    = (bus.npc_sel >= 4'd9);

`ifdef PC_EXC_EN
   assign bus.fetch_exc = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LAST);
`else
   logic unused_exc;
   assign unused_exc    = ^{bus.exc_req, bus.eret_req, bus.epc_in, EXC_VECTOR, IM_BASE, IM_LAST};
   assign bus.fetch_exc = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: vector table, randomized run against a reference model, reset and narrow-width wrap sequences.
module tb_pc_gen;

`ifdef PC_EXC_EN
   localparam bit EXC_EN = 1'b1;
`else
   localparam bit EXC_EN = 1'b0;
`endif

   localparam logic [31:0] D1 = 32'h0000_5000;
   localparam logic [31:0] D2 = 32'h0000_5100;
   localparam logic [31:0] D3 = 32'h0000_5200;

   logic clk = 1'b0;
   logic rst_n;
   logic rst8_n;
   always #5 clk = ~clk;

   pc_gen_if #(.WIDTH(32)) bus ();
   pc_gen_if #(.WIDTH(8))  bus8 ();

   pc_gen dut (.clk(clk), .reset(rst_n), .bus(bus));

   pc_gen #(
      .WIDTH(8), .RESET_PC(8'hFC), .EXC_VECTOR(8'h80), .IM_BASE(8'h00), .IM_LAST(8'hFC)
   ) dut8 (.clk(clk), .reset(rst8_n), .bus(bus8));

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        st;
      logic [3:0]  sel;
      logic        c;
      logic [31:0] br, j, jr;
      logic        ex, er;
      logic [31:0] epc;
      logic [31:0] e_pc;
      logic        e_pv, e_bad, e_fx;
   } vec_t;

   vec_t tbl[$];

   logic [31:0] m_pc, m_pt;
   logic        m_pv;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic [3:0] sel, input logic c,
                               input logic [31:0] br, j, jr, input logic ex, er,
                               input logic [31:0] epc, input logic [31:0] e_pc,
                               input logic e_pv, e_bad, e_fx);
      vec_t v;
      v.st = st; v.sel = sel; v.c = c; v.br = br; v.j = j; v.jr = jr;
      v.ex = ex; v.er = er; v.epc = epc;
      v.e_pc = e_pc; v.e_pv = e_pv; v.e_bad = e_bad; v.e_fx = e_fx;
      return v;
   endfunction

   task automatic drive(input logic st, input logic [3:0] sel, input logic c,
                        input logic [31:0] br, j, jr, input logic ex, er, input logic [31:0] epc);
      bus.stall = st; bus.npc_sel = sel; bus.cond = c;
      bus.br_target = br; bus.j_target = j; bus.jr_target = jr;
      bus.exc_req = ex; bus.eret_req = er; bus.epc_in = epc;
   endtask

   function automatic logic exp_fx(input logic [31:0] p);
      return EXC_EN && ((p % 4) != 0 || p < 32'h3000 || p > 32'h6FFC);
   endfunction

   // Reference: the next-PC priority list applied to the model state.
   task automatic model_edge(input logic st, input logic [3:0] sel, input logic c,
                             input logic [31:0] br, j, jr, input logic ex, er, input logic [31:0] epc);
      logic        tk;
      logic [31:0] tg;
      tk = ((sel >= 1 && sel <= 6) && c) || sel == 7 || sel == 8;
      tg = (sel == 7) ? j : (sel == 8) ? jr : br;
      if (EXC_EN && ex) begin m_pc = 32'h4180; m_pv = 1'b0; end
      else if (EXC_EN && er) begin m_pc = epc; m_pv = 1'b0; end
      else if (st) begin
         if (tk) begin m_pt = tg; m_pv = 1'b1; end
      end
      else if (tk) begin m_pc = tg; m_pv = 1'b0; end
      else if (m_pv) begin m_pc = m_pt; m_pv = 1'b0; end
      else m_pc = m_pc + 32'd4;
   endtask

   initial begin
      rst_n  = 1'b0;
      rst8_n = 1'b0;
      drive(0, 4'd0, 0, D1, D2, D3, 0, 0, 32'h0);
      bus8.stall = 0; bus8.npc_sel = 4'd0; bus8.cond = 0;
      bus8.br_target = 8'h0; bus8.j_target = 8'h0; bus8.jr_target = 8'h0;
      bus8.exc_req = 0; bus8.eret_req = 0; bus8.epc_in = 8'h0;

      // Rows: st sel c br j jr ex er epc | pc pend bad fx
      tbl.push_back(mk(0, 4'd0,  0, D1, D2, D3, 0, 0, 0, 32'h3004, 0, 0, 0));
      tbl.push_back(mk(0, 4'd0,  0, D1, D2, D3, 0, 0, 0, 32'h3008, 0, 0, 0));
      tbl.push_back(mk(0, 4'd0,  0, D1, D2, D3, 0, 0, 0, 32'h300C, 0, 0, 0));
      tbl.push_back(mk(0, 4'd0,  0, D1, D2, D3, 0, 0, 0, 32'h3010, 0, 0, 0));
      tbl.push_back(mk(0, 4'd1,  1, 32'h3100, D2, D3, 0, 0, 0, 32'h3100, 0, 0, 0));
      tbl.push_back(mk(0, 4'd7,  0, D1, 32'h3010, D3, 0, 0, 0, 32'h3010, 0, 0, 0));
      tbl.push_back(mk(0, 4'd1,  0, 32'h3100, D2, D3, 0, 0, 0, 32'h3014, 0, 0, 0));
      tbl.push_back(mk(1, 4'd8,  0, D1, D2, 32'h3400, 0, 0, 0, 32'h3014, 1, 0, 0));
      tbl.push_back(mk(1, 4'd0,  0, D1, D2, D3, 0, 0, 0, 32'h3014, 1, 0, 0));
      tbl.push_back(mk(1, 4'd1,  0, 32'h3100, D2, D3, 0, 0, 0, 32'h3014, 1, 0, 0));
      tbl.push_back(mk(0, 4'd0,  0, D1, D2, D3, 0, 0, 0, 32'h3400, 0, 0, 0));
      tbl.push_back(mk(1, 4'd7,  0, D1, 32'h3500, D3, 0, 0, 0, 32'h3400, 1, 0, 0));
      tbl.push_back(mk(1, 4'd8,  0, D1, D2, 32'h3600, 0, 0, 0, 32'h3400, 1, 0, 0));
      tbl.push_back(mk(0, 4'd1,  1, 32'h3700, D2, D3, 0, 0, 0, 32'h3700, 0, 0, 0));
      tbl.push_back(mk(0, 4'd0,  0, D1, D2, D3, 0, 0, 0, 32'h3704, 0, 0, 0));
      tbl.push_back(mk(0, 4'd12, 1, D1, D2, D3, 0, 0, 0, 32'h3708, 0, 1, 0));
      tbl.push_back(mk(1, 4'd12, 1, D1, D2, D3, 0, 0, 0, 32'h3708, 0, 1, 0));
      tbl.push_back(mk(1, 4'd7,  0, D1, 32'h3800, D3, 0, 0, 0, 32'h3708, 1, 0, 0));
      tbl.push_back(mk(0, 4'd15, 1, D1, D2, D3, 0, 0, 0, 32'h3800, 0, 1, 0));
      tbl.push_back(mk(0, 4'd3,  1, 32'h3200, D2, D3, 0, 0, 0, 32'h3200, 0, 0, 0));
      tbl.push_back(mk(0, 4'd6,  1, 32'h3300, D2, D3, 0, 0, 0, 32'h3300, 0, 0, 0));
      tbl.push_back(mk(0, 4'd4,  0, 32'h3300, D2, D3, 0, 0, 0, 32'h3304, 0, 0, 0));
      tbl.push_back(mk(0, 4'd9,  1, D1, D2, D3, 0, 0, 0, 32'h3308, 0, 1, 0));
      tbl.push_back(mk(0, 4'd8,  0, D1, D2, 32'h3002, 0, 0, 0, 32'h3002, 0, 0, EXC_EN));
      tbl.push_back(mk(0, 4'd7,  0, D1, 32'h7000, D3, 0, 0, 0, 32'h7000, 0, 0, EXC_EN));
      tbl.push_back(mk(0, 4'd7,  0, D1, 32'h6FFC, D3, 0, 0, 0, 32'h6FFC, 0, 0, 0));
      tbl.push_back(mk(0, 4'd7,  0, D1, 32'h2FFC, D3, 0, 0, 0, 32'h2FFC, 0, 0, EXC_EN));
      tbl.push_back(mk(0, 4'd7,  0, D1, 32'h3000, D3, 0, 0, 0, 32'h3000, 0, 0, 0));
      tbl.push_back(mk(1, 4'd7,  0, D1, 32'h3900, D3, 0, 0, 0, 32'h3000, 1, 0, 0));
      tbl.push_back(mk(1, 4'd0,  0, D1, D2, D3, 1, 0, 0,
                       EXC_EN ? 32'h4180 : 32'h3000, !EXC_EN, 0, 0));
      tbl.push_back(mk(0, 4'd0,  0, D1, D2, D3, 0, 1, 32'h3020,
                       EXC_EN ? 32'h3020 : 32'h3900, 0, 0, 0));
      tbl.push_back(mk(0, 4'd0,  0, D1, D2, D3, 1, 1, 32'h3020,
                       EXC_EN ? 32'h4180 : 32'h3904, 0, 0, 0));
      tbl.push_back(mk(0, 4'd7,  0, D1, 32'h3A00, D3, 1, 0, 0,
                       EXC_EN ? 32'h4180 : 32'h3A00, 0, 0, 0));
      tbl.push_back(mk(0, 4'd8,  0, D1, D2, 32'h3002, 0, 0, 0, 32'h3002, 0, 0, EXC_EN));
      tbl.push_back(mk(0, 4'd0,  0, D1, D2, D3, 1, 0, 0,
                       EXC_EN ? 32'h4180 : 32'h3006, 0, 0, 0));
      tbl.push_back(mk(0, 4'd7,  0, D1, 32'h3000, D3, 0, 0, 0, 32'h3000, 0, 0, 0));

      // Reset held across clock edges
      repeat (2) @(posedge clk);
      #1;
      chk("reset pc",    bus.pc,         32'h3000);
      chk("reset pc4",   bus.pc4,        32'h3004);
      chk("reset pc8",   bus.pc8,        32'h3008);
      chk("reset pend",  bus.pend_valid, 1'b0);
      chk("reset fx",    bus.fetch_exc,  1'b0);
      chk("w8 reset pc",  bus8.pc,  8'hFC);
      chk("w8 reset pc4", bus8.pc4, 8'h00);
      chk("w8 reset pc8", bus8.pc8, 8'h04);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].sel, tbl[i].c, tbl[i].br, tbl[i].j, tbl[i].jr,
               tbl[i].ex, tbl[i].er, tbl[i].epc);
         #1;
         chk($sformatf("row%0d bad_sel", i), bus.bad_sel, tbl[i].e_bad);
         @(posedge clk);
         #1;
         chk($sformatf("row%0d pc", i),   bus.pc,         tbl[i].e_pc);
         chk($sformatf("row%0d pend", i), bus.pend_valid, tbl[i].e_pv);
         chk($sformatf("row%0d pc4", i),  bus.pc4,        tbl[i].e_pc + 32'd4);
         chk($sformatf("row%0d pc8", i),  bus.pc8,        tbl[i].e_pc + 32'd8);
         chk($sformatf("row%0d fx", i),   bus.fetch_exc,  tbl[i].e_fx);
      end

      // Randomized run against the reference model, starting from pc=0x3000, nothing pending
      m_pc = 32'h3000;
      m_pv = 1'b0;
      m_pt = 32'h0;
      for (int n = 0; n < 400; n++) begin
         logic        st, c, ex, er;
         logic [3:0]  sel;
         logic [31:0] br, j, jr, epc;
         st  = ($urandom_range(0, 3) == 0);
         sel = 4'($urandom_range(0, 15));
         c   = 1'($urandom_range(0, 1));
         br  = 32'h3000 + 32'($urandom_range(0, 32'h0FFF)) * 4 + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
         j   = 32'h3000 + 32'($urandom_range(0, 32'h0FFF)) * 4 + (($urandom_range(0, 9) == 0) ? 32'h4000 : 32'd0);
         jr  = 32'h2F00 + 32'($urandom_range(0, 32'h103F)) * 4 + 32'($urandom_range(0, 1)) * 2;
         ex  = ($urandom_range(0, 19) == 0);
         er  = ($urandom_range(0, 19) == 0);
         epc = 32'h3000 + 32'($urandom_range(0, 32'h0FFF)) * 4;
         drive(st, sel, c, br, j, jr, ex, er, epc);
         #1;
         chk($sformatf("rnd%0d bad_sel", n), bus.bad_sel, (sel >= 9));
         model_edge(st, sel, c, br, j, jr, ex, er, epc);
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d pc", n),   bus.pc,         m_pc);
         chk($sformatf("rnd%0d pend", n), bus.pend_valid, m_pv);
         chk($sformatf("rnd%0d pc8", n),  bus.pc8,        m_pc + 32'd8);
         chk($sformatf("rnd%0d fx", n),   bus.fetch_exc,  exp_fx(m_pc));
      end

      // Reset in mid-operation discards a buffered redirect
      drive(1, 4'd7, 0, D1, 32'h3B00, D3, 0, 0, 0);
      model_edge(1, 4'd7, 0, D1, 32'h3B00, D3, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("midrst pend before", bus.pend_valid, 1'b1);
      chk("midrst pc before",   bus.pc,         m_pc);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst async pc",   bus.pc,         32'h3000);
      chk("midrst async pend", bus.pend_valid, 1'b0);
      chk("midrst async fx",   bus.fetch_exc,  1'b0);
      drive(0, 4'd0, 0, D1, D2, D3, 0, 0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst after pc",   bus.pc,         32'h3004);
      chk("midrst after pend", bus.pend_valid, 1'b0);

      // Narrow instance: PC+4 wraps silently from 0xFC to 0x00
      rst8_n = 1'b1;
      @(posedge clk);
      #1;
      chk("w8 wrap pc",  bus8.pc,  8'h00);
      chk("w8 wrap pc4", bus8.pc4, 8'h04);
      chk("w8 wrap fx",  bus8.fetch_exc, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
